// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer for the shared memory port; req/ack to requesters, timed MEM_* bus to memory.
// Optional `MEM_ARB_RR_EN selects round-robin arbitration; default build is fixed priority (port 0 wins).
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned MEM_LAT    = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic                  REQ1,
    input  logic                  WE0,
    input  logic                  WE1,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [DATA_WIDTH-1:0] WDATA0,
    input  logic [DATA_WIDTH-1:0] WDATA1,
    output logic [DATA_WIDTH-1:0] RDATA0,
    output logic [DATA_WIDTH-1:0] RDATA1,
    output logic                  ACK0,
    output logic                  ACK1,
    output logic                  GNT,
    output logic                  BUSY,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    inout  wire  [DATA_WIDTH-1:0] MEM_DATA
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  sel1;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

`ifdef MEM_ARB_RR_EN
    // Pointer holds the last granted port; on contention the other port wins.
    logic rr_ptr;
    assign sel1 = REQ1 & (~REQ0 | ~rr_ptr);
`else
    assign sel1 = REQ1 & ~REQ0;
`endif

    always_comb begin
        sel_we    = WE0;
        sel_addr  = ADDR0;
        sel_wdata = WDATA0;
        if (sel1) begin
            sel_we    = WE1;
            sel_addr  = ADDR1;
            sel_wdata = WDATA1;
        end
    end

    // Bus is driven only while a write access is on the port.
    assign MEM_DATA = MEM_WRITE ? wdata_q : {DATA_WIDTH{1'bz}};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            GNT       <= 1'b0;
            BUSY      <= 1'b0;
            ACK0      <= 1'b0;
            ACK1      <= 1'b0;
            RDATA0    <= '0;
            RDATA1    <= '0;
            MEM_ADDR  <= '0;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_ptr    <= 1'b1;
`endif
        end else begin
            ACK0 <= 1'b0;
            ACK1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ0 || REQ1) begin
                        GNT       <= sel1;
                        BUSY      <= 1'b1;
                        we_q      <= sel_we;
                        wdata_q   <= sel_wdata;
                        MEM_ADDR  <= sel_addr;
                        MEM_READ  <= ~sel_we;
                        MEM_WRITE <= sel_we;
                        cnt       <= CNT_W'(MEM_LAT);
                        state     <= ACCESS;
`ifdef MEM_ARB_RR_EN
                        rr_ptr    <= sel1;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt == CNT_W'(1)) begin
                        if (!we_q) begin
                            if (GNT) RDATA1 <= MEM_DATA;
                            else     RDATA0 <= MEM_DATA;
                        end
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        ACK0      <= ~GNT;
                        ACK1      <= GNT;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=3.
// Each instance has its own small memory model on its MEM_* bus.
module tb_mem_port_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 26;

    logic clk = 1'b0;
    logic rst_n;

    logic [1:0]         req0, req1, we0, we1;
    logic [1:0][AW-1:0] addr0, addr1;
    logic [1:0][DW-1:0] wdata0, wdata1;

    wire  [1:0][DW-1:0] rdata0, rdata1;
    wire  [1:0]         ack0, ack1, gnt, busy, mem_read, mem_write;
    wire  [1:0][AW-1:0] mem_addr;
    wire  [DW-1:0]      md_a, md_b;

    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];
    logic [1:0]    last_gnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LAT(1)) u_dut_a (
        .CLK(clk), .RST(rst_n),
        .REQ0(req0[0]), .REQ1(req1[0]), .WE0(we0[0]), .WE1(we1[0]),
        .ADDR0(addr0[0]), .ADDR1(addr1[0]), .WDATA0(wdata0[0]), .WDATA1(wdata1[0]),
        .RDATA0(rdata0[0]), .RDATA1(rdata1[0]), .ACK0(ack0[0]), .ACK1(ack1[0]),
        .GNT(gnt[0]), .BUSY(busy[0]), .MEM_ADDR(mem_addr[0]),
        .MEM_READ(mem_read[0]), .MEM_WRITE(mem_write[0]), .MEM_DATA(md_a)
    );

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LAT(3)) u_dut_b (
        .CLK(clk), .RST(rst_n),
        .REQ0(req0[1]), .REQ1(req1[1]), .WE0(we0[1]), .WE1(we1[1]),
        .ADDR0(addr0[1]), .ADDR1(addr1[1]), .WDATA0(wdata0[1]), .WDATA1(wdata1[1]),
        .RDATA0(rdata0[1]), .RDATA1(rdata1[1]), .ACK0(ack0[1]), .ACK1(ack1[1]),
        .GNT(gnt[1]), .BUSY(busy[1]), .MEM_ADDR(mem_addr[1]),
        .MEM_READ(mem_read[1]), .MEM_WRITE(mem_write[1]), .MEM_DATA(md_b)
    );

    // Memory models: combinational read drive, write on rising edge.
    assign md_a = mem_read[0] ? mem_a[mem_addr[0][7:0]] : {DW{1'bz}};
    assign md_b = mem_read[1] ? mem_b[mem_addr[1][7:0]] : {DW{1'bz}};

    always @(posedge clk) begin
        if (mem_write[0]) mem_a[mem_addr[0][7:0]] <= md_a;
        if (mem_write[1]) mem_b[mem_addr[1][7:0]] <= md_b;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("mutex", {ack0[0] & ack1[0], mem_read[0] & mem_write[0],
                            ack0[1] & ack1[1], mem_read[1] & mem_write[1]}, 4'b0);
        end
    end

    // One transaction on instance d from port p; called on a falling edge with the instance idle.
    task automatic run_xact(input string tag, input int d, input bit p, input bit we,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input logic [DW-1:0] exp_rd, input bit drop_early);
        int n;
        int lat;
        logic [DW-1:0] md;
        lat = (d == 1) ? 3 : 1;
        if (p) begin req1[d] = 1'b1; we1[d] = we; addr1[d] = a; wdata1[d] = wd; end
        else   begin req0[d] = 1'b1; we0[d] = we; addr0[d] = a; wdata0[d] = wd; end
        @(negedge clk);
        n = 1;
        check({tag, ":gnt"}, gnt[d], p);
        check({tag, ":busy"}, busy[d], 1);
        if (p) begin addr1[d] = ~a; wdata1[d] = ~wd; if (drop_early) req1[d] = 1'b0; end
        else   begin addr0[d] = ~a; wdata0[d] = ~wd; if (drop_early) req0[d] = 1'b0; end
        while (!(ack0[d] | ack1[d]) && n < 40) begin
            md = (d == 1) ? md_b : md_a;
            check({tag, ":rw"}, {mem_read[d], mem_write[d]}, {~we, we});
            check({tag, ":addr"}, mem_addr[d], a);
            if (we) check({tag, ":wdata"}, md, wd);
            @(negedge clk);
            n++;
        end
        check({tag, ":lat"}, n, lat + 1);
        check({tag, ":ack"}, {ack1[d], ack0[d]}, p ? 2'b10 : 2'b01);
        check({tag, ":ack_rw"}, {mem_read[d], mem_write[d]}, 2'b00);
        check({tag, ":ack_busy"}, busy[d], 1);
        if (!we) check({tag, ":rdata"}, p ? rdata1[d] : rdata0[d], exp_rd);
        last_gnt[d] = p;
        if (p) req1[d] = 1'b0; else req0[d] = 1'b0;
        @(negedge clk);
        check({tag, ":idle_busy"}, busy[d], 0);
        check({tag, ":idle_ack"}, {ack1[d], ack0[d]}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  exp_p;
        rst_n = 1'b0;
        req0 = '0; req1 = '0; we0 = '0; we1 = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        last_gnt = 2'b11;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_a[8'h00] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            check("rst:busy", busy[d], 0);
            check("rst:gnt", gnt[d], 0);
            check("rst:ack", {ack1[d], ack0[d]}, 2'b00);
            check("rst:rw", {mem_read[d], mem_write[d]}, 2'b00);
            check("rst:addr", mem_addr[d], 0);
            check("rst:rdata", {rdata1[d], rdata0[d]}, 64'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Instance 0, MEM_LAT = 1
        run_xact("a_rd0", 0, 1'b0, 1'b0, 26'h0001000, 32'h0, 32'hDEADBEEF, 1'b0);
        check("a_rd0:rdata1", rdata1[0], 0);
        run_xact("a_wr1", 0, 1'b1, 1'b1, 26'h0000020, 32'hCAFEF00D, 32'h0, 1'b0);
        run_xact("a_rb0", 0, 1'b0, 1'b0, 26'h0000020, 32'h0, 32'hCAFEF00D, 1'b0);
        run_xact("a_drop", 0, 1'b0, 1'b0, 26'h0001000, 32'h0, 32'hDEADBEEF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("a_drop:no_retx", busy[0], 0);
            @(negedge clk);
        end
        run_xact("a_rd1", 0, 1'b1, 1'b0, 26'h0001000, 32'h0, 32'hDEADBEEF, 1'b0);
        check("a_rd1:rdata0_held", rdata0[0], 32'hDEADBEEF);

        // Both ports requesting continuously
        req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 26'h0001000;
        req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 26'h0000020;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(ack0[0] | ack1[0]) && n < 20);
`ifdef MEM_ARB_RR_EN
            exp_p = ~last_gnt[0];
`else
            exp_p = 1'b0;
`endif
            check("cont:ack", {ack1[0], ack0[0]}, exp_p ? 2'b10 : 2'b01);
            check("cont:gap", n, (i == 0) ? 2 : 3);
            check("cont:rdata", exp_p ? rdata1[0] : rdata0[0],
                  exp_p ? 32'hCAFEF00D : 32'hDEADBEEF);
            last_gnt[0] = exp_p;
        end
        req0[0] = 1'b0;
        req1[0] = 1'b0;
        @(negedge clk);
        check("cont:end_busy", busy[0], 0);
        @(negedge clk);
        check("cont:no_grant", busy[0], 0);

        // Instance 1, MEM_LAT = 3
        run_xact("b_wr1", 1, 1'b1, 1'b1, 26'h0000010, 32'h12345678, 32'h0, 1'b0);
        run_xact("b_rb0", 1, 1'b0, 1'b0, 26'h0000010, 32'h0, 32'h12345678, 1'b0);

        // Reset in the middle of a write access
        req1[1] = 1'b1; we1[1] = 1'b1; addr1[1] = 26'h0000030; wdata1[1] = 32'h55AA55AA;
        @(negedge clk);
        check("rstw:pre_write", mem_write[1], 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstw:write", mem_write[1], 0);
        check("rstw:busy", busy[1], 0);
        check("rstw:ack", {ack1[1], ack0[1]}, 2'b00);
        check("rstw:rdata0", rdata0[1], 0);
        req1[1] = 1'b0;
        last_gnt = 2'b11;
        @(negedge clk);
        check("rstw:held_ack", {ack1[1], ack0[1]}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);
        run_xact("b_rewr", 1, 1'b1, 1'b1, 26'h0000030, 32'h55AA55AA, 32'h0, 1'b0);
        run_xact("b_rerd", 1, 1'b0, 1'b0, 26'h0000030, 32'h0, 32'h55AA55AA, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
